fetch_cycle: RTL and testbench
==============================

// Module: fetch_cycle
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline. Owns the PC, the word-addressed instruction memory and the IF/ID pipeline register.
//   Produces instrD/pcD/pcplus4D for the decode stage.
//   Accepts stall/flush from hazard control and a PC redirect resolved in EX (branch taken / jump).
// PARAMETERS
//   IMEM_DEPTH   256            instruction memory size in 32-bit words (power of 2, >=2)
//   RESET_PC     32'h00000000   PC value loaded on reset
// PORTS
//   clk          in   1    clock, all state updates on posedge
//   rst          in   1    synchronous reset, active-high
//   stallF       in   1    hold PC and IF/ID contents
//   flushD       in   1    load bubble into IF/ID
//   pcsrcE       in   1    redirect request from EX (taken branch or jump)
//   pctargetE    in   32   redirect target address
//   imem_we      in   1    instruction memory write enable (program load)
//   imem_waddr   in   32   byte address of word to write
//   imem_wdata   in   32   word to write
//   instrD       out  32   instruction to decode
//   pcD          out  32   PC of instrD
//   pcplus4D     out  32   pcD + 4
//   validD       out  1    1 = IF/ID holds a real fetched instruction, 0 = bubble
//   pcF          out  32   current fetch PC
//   fetchcnt     out  32   count of valid instructions loaded into IF/ID
// BEHAVIOUR
//   Fetch: instrF = imem[pcF[log2(IMEM_DEPTH)+1:2]] (combinational read).
//     instrF = 32'h0 (NOP) when pcF[31:2] >= IMEM_DEPTH. pcF[1:0] ignored.
//   pcplus4F = pcF + 4, mod 2^32: 32'hFFFFFFFC wraps to 0.
//   Per-edge priority: rst > pcsrcE > stallF > normal.
//   rst: pcF <= RESET_PC; IF/ID <= bubble; fetchcnt <= 0; imem contents NOT cleared.
//   pcsrcE=1: pcF <= {pctargetE[31:2],2'b00}; IF/ID <= bubble. Ignores stallF and flushD.
//   stallF=1, pcsrcE=0:
//     pcF holds.
//     IF/ID holds if flushD=0; if flushD=1, IF/ID <= bubble.
//   normal (pcsrcE=0, stallF=0):
//     pcF <= pcplus4F.
//     flushD=0: IF/ID <= {instrF, pcF, pcplus4F, valid=1}.
//     flushD=1: IF/ID <= bubble.
//   Bubble = instrD 32'h0, pcD 0, pcplus4D 0, validD 0.
//   Outputs after reset: instrD=0, pcD=0, pcplus4D=0, validD=0, pcF=RESET_PC, fetchcnt=0.
//   fetchcnt increments by 1 on each edge where IF/ID is loaded with validD=1 (normal, no flush).
//     Holds on stall. Wraps 32'hFFFFFFFF -> 0.
//   Latency: word at pcF appears on instrD one cycle after the fetching edge.
//     A redirect costs exactly one bubble in IF/ID.
//   imem write: imem[imem_waddr[..:2]] <= imem_wdata on posedge when imem_we=1.
//     Out-of-range address is dropped.
//     Fetch of the same word in the write cycle returns the old word; new word is visible from the next cycle.
//     The write also takes place during rst.
// TESTING
//   1. Load imem[0..3]=A,B,C,D; release rst -> instrD=A,B,C,D on cycles 1-4; pcD=0,4,8,C; fetchcnt=4.
//   2. Stall after B -> instrD=B and pcF=8 held for every stall cycle; fetchcnt frozen;
//      on release, instrD=C next cycle.
//   3. pcsrcE=1, pctargetE=32'h0000000E while stallF=1 -> pcF=32'hC next cycle, validD=0;
//      following cycle instrD=imem[3], pcD=C.
//   4. stallF=1, flushD=1 -> pcF holds; instrD=0, validD=0; fetchcnt does not increment.
//   5. RESET_PC=32'hFFFFFFFC -> instrD=0 (out of range), pcplus4D=0, then pcF=0 fetches imem[0].
//   6. Assert rst mid-stream with imem_we=1 to addr 8 -> pcF=RESET_PC, validD=0;
//      imem[2] holds new word; other words unchanged.

Source files
------------

// File: rtl/fetch_cycle.sv
// IF stage: owns the PC, a word-addressed instruction memory and the IF/ID pipeline register.
// Latency: the word at pcF appears on instrD one cycle after the fetching edge; a redirect costs one bubble.
// Backpressure: stallF freezes the PC and IF/ID, flushD loads a bubble, pcsrcE overrides both.
module fetch_cycle #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        flushD,
    input  logic        pcsrcE,
    input  logic [31:0] pctargetE,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic [31:0] pcF,
    output logic [31:0] fetchcnt
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0] imem [IMEM_DEPTH];

    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] pcd_q,      pcd_d;
    logic [31:0] pcp4d_q,    pcp4d_d;
    logic        valid_q,    valid_d;
    logic [31:0] cnt_q,      cnt_d;

    logic [31:0] pc_word;
    logic [31:0] waddr_word;
    logic        fetch_in_range;
    logic        write_in_range;
    logic [31:0] instr_f;
    logic [31:0] pcplus4_f;

    // Word indices; the byte-offset bits of both addresses are deliberately discarded.
    assign pc_word        = pc_q >> 2;
    assign waddr_word     = imem_waddr >> 2;
    assign fetch_in_range = (pc_word < 32'(IMEM_DEPTH));
    assign write_in_range = (waddr_word < 32'(IMEM_DEPTH));

    // Combinational fetch; anything past the end of memory reads as a NOP.
    always_comb begin
        instr_f   = 32'h0;
        if (fetch_in_range) begin
            instr_f = imem[pc_word[AW-1:0]];
        end
        pcplus4_f = pc_q + 32'd4;
    end

    // Next-state selection with priority redirect > stall > normal advance.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4d_d = pcp4d_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (pcsrcE) begin
            pc_d    = pctargetE & 32'hFFFF_FFFC;
            instr_d = 32'h0;
            pcd_d   = 32'h0;
            pcp4d_d = 32'h0;
            valid_d = 1'b0;
        end else if (stallF) begin
            if (flushD) begin
                instr_d = 32'h0;
                pcd_d   = 32'h0;
                pcp4d_d = 32'h0;
                valid_d = 1'b0;
            end
        end else begin
            pc_d = pcplus4_f;
            if (flushD) begin
                instr_d = 32'h0;
                pcd_d   = 32'h0;
                pcp4d_d = 32'h0;
                valid_d = 1'b0;
            end else begin
                instr_d = instr_f;
                pcd_d   = pc_q;
                pcp4d_d = pcplus4_f;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 32'd1;
            end
        end
    end

    // PC, IF/ID register and fetch counter; reset overrides every other request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pcd_q   <= 32'h0;
            pcp4d_q <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4d_q <= pcp4d_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Program load port; runs through reset so code can be loaded while the core is held.
    always_ff @(posedge clk) begin
        if (imem_we && write_in_range) begin
            imem[waddr_word[AW-1:0]] <= imem_wdata;
        end
    end

    assign instrD   = instr_q;
    assign pcD      = pcd_q;
    assign pcplus4D = pcp4d_q;
    assign validD   = valid_q;
    assign pcF      = pc_q;
    assign fetchcnt = cnt_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Bench for fetch_cycle: directed vector table, hand-written corner sequences, then random traffic.
// Expected values come from constants and a cycle-level reference model kept in the bench.
// A second instance with RESET_PC=32'hFFFFFFFC covers the top-of-address-space start.
module tb_fetch_cycle;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst, stallF, flushD, pcsrcE, imem_we;
    logic [31:0] pctargetE, imem_waddr, imem_wdata;
    logic [31:0] instrD, pcD, pcplus4D, pcF, fetchcnt;
    logic        validD;
    logic [31:0] instrD2, pcD2, pcplus4D2, pcF2, fetchcnt2;
    logic        validD2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_cycle #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .stallF(stallF), .flushD(flushD), .pcsrcE(pcsrcE),
        .pctargetE(pctargetE), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
        .validD(validD), .pcF(pcF), .fetchcnt(fetchcnt)
    );

    fetch_cycle #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) u_dut_top (
        .clk(clk), .rst(rst), .stallF(1'b0), .flushD(1'b0), .pcsrcE(1'b0),
        .pctargetE(32'h0), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .instrD(instrD2), .pcD(pcD2), .pcplus4D(pcplus4D2),
        .validD(validD2), .pcF(pcF2), .fetchcnt(fetchcnt2)
    );

    // Reference model state: the program as an array, the PC, the IF/ID contents and the counter.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_instr, m_pcD, m_pc4, m_cnt;
    logic        m_valid;

    function automatic logic [31:0] w(int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic model_bubble();
        m_instr = 32'h0; m_pcD = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    // One clock edge of the stage, taken straight from the behavioural rules.
    task automatic model_edge();
        logic [31:0] f_instr;
        logic [31:0] f_pc4;
        f_instr = ((m_pc >> 2) < DEPTH) ? m_mem[(m_pc >> 2) % DEPTH] : 32'h0;
        f_pc4   = m_pc + 32'd4;
        if (rst) begin
            m_pc = 32'h0; model_bubble(); m_cnt = 32'h0;
        end else if (pcsrcE) begin
            m_pc = {pctargetE[31:2], 2'b00}; model_bubble();
        end else if (stallF) begin
            if (flushD) model_bubble();
        end else begin
            if (flushD) begin
                model_bubble();
            end else begin
                m_instr = f_instr; m_pcD = m_pc; m_pc4 = f_pc4; m_valid = 1'b1;
                m_cnt = m_cnt + 32'd1;
            end
            m_pc = f_pc4;
        end
        if (imem_we && ((imem_waddr >> 2) < DEPTH)) m_mem[(imem_waddr >> 2) % DEPTH] = imem_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " instrD"},   instrD,   m_instr);
        chk({tag, " pcD"},      pcD,      m_pcD);
        chk({tag, " pcplus4D"}, pcplus4D, m_pc4);
        chk({tag, " validD"},   {31'h0, validD}, {31'h0, m_valid});
        chk({tag, " pcF"},      pcF,      m_pc);
        chk({tag, " fetchcnt"}, fetchcnt, m_cnt);
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic        pcsrc;
        logic [31:0] target;
        logic [31:0] e_instr;
        logic [31:0] e_pcD;
        logic        e_valid;
        logic [31:0] e_pcF;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // Directed sequence starting right after reset release with imem[i] = w(i).
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,    w(0), 32'h0,    1'b1, 32'h4,    32'd1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,    w(1), 32'h4,    1'b1, 32'h8,    32'd2};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,    w(1), 32'h4,    1'b1, 32'h8,    32'd2};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,    w(1), 32'h4,    1'b1, 32'h8,    32'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,    w(2), 32'h8,    1'b1, 32'hC,    32'd3};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,    w(3), 32'hC,    1'b1, 32'h10,   32'd4};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'hE,    32'h0, 32'h0,   1'b0, 32'hC,    32'd4};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,    w(3), 32'hC,    1'b1, 32'h10,   32'd5};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,    32'h0, 32'h0,   1'b0, 32'h10,   32'd5};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,    w(4), 32'h10,   1'b1, 32'h14,   32'd6};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h0, 32'h0,   1'b0, 32'h18,   32'd6};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,    w(6), 32'h18,   1'b1, 32'h1C,   32'd7};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h1003, 32'h0, 32'h0,   1'b0, 32'h1000, 32'd7};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,    32'h0, 32'h1000, 1'b1, 32'h1004, 32'd8};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h0, 32'h0,   1'b0, 32'h0,    32'd8};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,    w(0), 32'h0,    1'b1, 32'h4,    32'd9};

        rst = 1'b1; stallF = 1'b0; flushD = 1'b0; pcsrcE = 1'b0; pctargetE = 32'h0;
        imem_we = 1'b0; imem_waddr = 32'h0; imem_wdata = 32'h0;
        m_pc = 32'h0; m_cnt = 32'h0; model_bubble();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

        // Program load while held in reset.
        for (int i = 0; i < DEPTH; i++) begin
            imem_we = 1'b1; imem_waddr = 32'(i * 4); imem_wdata = w(i);
            tick();
        end
        imem_we = 1'b0;
        chk("reset instrD",   instrD,   32'h0);
        chk("reset pcD",      pcD,      32'h0);
        chk("reset pcplus4D", pcplus4D, 32'h0);
        chk("reset validD",   {31'h0, validD}, 32'h0);
        chk("reset pcF",      pcF,      32'h0);
        chk("reset fetchcnt", fetchcnt, 32'h0);
        chk("reset pcF top",  pcF2,     32'hFFFF_FFFC);

        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            stallF = vecs[i].stall; flushD = vecs[i].flush;
            pcsrcE = vecs[i].pcsrc; pctargetE = vecs[i].target;
            tick();
            chk($sformatf("vec%0d instrD", i),   instrD,   vecs[i].e_instr);
            chk($sformatf("vec%0d pcD", i),      pcD,      vecs[i].e_pcD);
            chk($sformatf("vec%0d pcplus4D", i), pcplus4D, vecs[i].e_valid ? vecs[i].e_pcD + 32'd4 : 32'h0);
            chk($sformatf("vec%0d validD", i),   {31'h0, validD}, {31'h0, vecs[i].e_valid});
            chk($sformatf("vec%0d pcF", i),      pcF,      vecs[i].e_pcF);
            chk($sformatf("vec%0d fetchcnt", i), fetchcnt, vecs[i].e_cnt);
            if (i == 0) begin
                chk("top first instrD",   instrD2,   32'h0);
                chk("top first pcD",      pcD2,      32'hFFFF_FFFC);
                chk("top first pcplus4D", pcplus4D2, 32'h0);
                chk("top first pcF",      pcF2,      32'h0);
            end
            if (i == 1) begin
                chk("top second instrD", instrD2, w(0));
                chk("top second pcD",    pcD2,    32'h0);
                chk("top fetchcnt",      fetchcnt2, 32'd2);
            end
        end
        stallF = 1'b0; flushD = 1'b0; pcsrcE = 1'b0;

        // Reset mid-stream with a concurrent program write to word 2.
        rst = 1'b1; imem_we = 1'b1; imem_waddr = 32'h8; imem_wdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; imem_we = 1'b0;
        chk("midrst pcF",      pcF,      32'h0);
        chk("midrst validD",   {31'h0, validD}, 32'h0);
        chk("midrst fetchcnt", fetchcnt, 32'h0);
        tick(); chk("midrst w0", instrD, w(0));
        tick(); chk("midrst w1", instrD, w(1));
        tick(); chk("midrst w2 new", instrD, 32'hDEAD_BEEF);
        tick(); chk("midrst w3", instrD, w(3));

        // Write to the word being fetched: old word now, new word on refetch.
        imem_we = 1'b1; imem_waddr = 32'h10; imem_wdata = 32'h5555_AAAA;
        tick(); chk("wr same cycle old", instrD, w(4));
        imem_we = 1'b0; pcsrcE = 1'b1; pctargetE = 32'h10;
        tick(); chk("redirect bubble", {31'h0, validD}, 32'h0);
        pcsrcE = 1'b0;
        tick(); chk("wr refetch new", instrD, 32'h5555_AAAA);

        // Out-of-range write must not alias onto word 0.
        imem_we = 1'b1; imem_waddr = 32'h400; imem_wdata = 32'hBAD0_BAD0;
        pcsrcE = 1'b1; pctargetE = 32'h0;
        tick();
        imem_we = 1'b0; pcsrcE = 1'b0;
        tick(); chk("oor write dropped", instrD, w(0));
        chk_model("post-directed");

        // Randomised traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            stallF     = ($urandom_range(0, 3) == 0);
            flushD     = ($urandom_range(0, 6) == 0);
            pcsrcE     = ($urandom_range(0, 9) == 0);
            pctargetE  = ($urandom_range(0, 19) == 0) ? $urandom() : 32'($urandom_range(0, 32'h47F));
            imem_we    = ($urandom_range(0, 4) == 0);
            imem_waddr = 32'($urandom_range(0, 32'h4FF));
            imem_wdata = $urandom();
            tick();
            chk_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
